regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Sequences all accesses to the 32x32 register file (1 write port, 2 async read ports, RAM-based) in the 3-stage RISC-V pipeline.
- The pipeline's writeback and read ports have priority.
- A debug requester shares write port D and read port B through a valid/ready request and response handshake.
- A starvation counter stalls the pipeline so debug always completes.
- The block also enforces x0 = 0 and forwards same-cycle writes to both pipeline read ports.

Parameters:
- DWIDTH, 32, register data width
- AWIDTH, 5, register address width
- STARVE_LIMIT, 8, number of WAIT cycles without a free slot before pipe_stall asserts (must be >= 1)
- CNT_W, 4, width of the wait counter; must hold STARVE_LIMIT

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_we  in  1  pipeline writeback enable
- wb_addr  in  AWIDTH  pipeline writeback address
- wb_data  in  DWIDTH  pipeline writeback data
- pipe_addr_a  in  AWIDTH  pipeline read address A
- pipe_addr_b  in  AWIDTH  pipeline read address B
- pipe_rb_used  in  1  pipeline needs read port B this cycle
- pipe_data_a  out  DWIDTH  forwarded read data A
- pipe_data_b  out  DWIDTH  forwarded read data B
- pipe_stall  out  1  registered; pipeline must hold wb_we=0 and pipe_rb_used=0 while high
- rf_we  out  1  to regfile write enable
- rf_addr_d  out  AWIDTH  to regfile write address
- rf_data_d  out  DWIDTH  to regfile write data
- rf_addr_a  out  AWIDTH  to regfile read address A (= pipe_addr_a)
- rf_addr_b  out  AWIDTH  to regfile read address B (muxed)
- rf_data_a  in  DWIDTH  from regfile read data A
- rf_data_b  in  DWIDTH  from regfile read data B
- dbg_req_valid  in  1  debug request valid
- dbg_req_ready  out  1  debug request accepted when valid&&ready
- dbg_req_write  in  1  1 = write, 0 = read
- dbg_req_addr  in  AWIDTH  debug register address
- dbg_req_wdata  in  DWIDTH  debug write data
- dbg_rsp_valid  out  1  response valid, held until accepted
- dbg_rsp_ready  in  1  response accept
- dbg_rsp_rdata  out  DWIDTH  read data; 0 for writes

Behaviour:
- Reset values:
  - state = IDLE; pipe_stall = 0; dbg_rsp_valid = 0; dbg_rsp_rdata = 0; wait counter = 0.
  - dbg_req_ready = 0 while rst is high.
- FSM states: IDLE, WAIT, RSP.
- IDLE:
  - dbg_req_ready = 1.
  - On valid&&ready: latch write/addr/wdata, then go to WAIT.
- WAIT:
  - dbg_req_ready = 0.
  - The grant condition for a write is (!wb_we || pipe_stall).
  - The grant condition for a read is (!pipe_rb_used || pipe_stall).
  - On the grant cycle, go to RSP and clear the counter.
  - Otherwise, increment the counter, saturating at STARVE_LIMIT.
- pipe_stall:
  - Registered; asserts the cycle after the counter reaches STARVE_LIMIT.
  - Stays high through the grant cycle.
  - Is 0 in the cycle after the grant.
- RSP:
  - dbg_rsp_valid = 1, with stable data, until dbg_rsp_ready.
  - On dbg_rsp_ready, return to IDLE; dbg_req_ready is 1 in the following cycle.
- Latency: request accepted at T, earliest grant at T+1, dbg_rsp_valid at T+2.
- Write port mux:
  - Debug write granted: rf_we = 1, address and data from the latch.
  - Otherwise: rf_we = wb_we, address and data from wb.
  - rf_we is forced to 0 when the selected address is 0. A debug write to x0 still completes with a response, and the register file is unchanged.
- rf_addr_b: the latched debug address during a debug read grant, otherwise pipe_addr_b.
- Debug read capture:
  - dbg_rsp_rdata <= forwarded value of the latched address, using the same forwarding rule as the pipeline ports.
  - A debug read sees a same-cycle wb write to the same nonzero address.
- Forwarding, applied independently to ports A and B:
  - data = 0 if the address is 0.
  - Else rf_data_d if rf_we && rf_addr_d == address.
  - Else rf_data_x.
- Reset mid-operation: the pending request and response are dropped and the state returns to IDLE. No register-file write occurs in the reset cycle (rf_we = 0 while rst).

Test Plan:
1. Reset, then dbg write x5 = 0xDEADBEEF with wb_we = 0 → rf_we pulses at T+1 with addr 5; dbg_rsp_valid at T+2, rdata 0. A following dbg read of x5 returns 0xDEADBEEF.
2. wb_we = 1, wb_addr = 7, wb_data = 0x12345678, pipe_addr_a = 7 in the same cycle → pipe_data_a = 0x12345678. Then wb write to x0 with data 0xFFFFFFFF → rf_we = 0, and a read of x0 returns 0.
3. wb_we held at 1 continuously during a pending dbg write, STARVE_LIMIT = 8 → pipe_stall asserts after 8 WAIT cycles, grant occurs while stalled, pipe_stall is 0 the cycle after the grant.
4. dbg read of x3 while pipe_rb_used toggles 1,1,0 → grant on the third WAIT cycle, rf_addr_b = 3 only in that cycle, pipe_stall never asserts.
5. dbg_rsp_ready held at 0 for 5 cycles → dbg_rsp_valid and rdata stay stable, dbg_req_ready = 0. Release → IDLE next cycle.
6. rst asserted while in WAIT → next cycle: IDLE, pipe_stall = 0, dbg_rsp_valid = 0, no rf_we pulse.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitrates the 32x32 register file between the pipeline and a debug requester.
// The pipeline has priority. A starvation counter stalls the pipeline so that a debug access always completes.
// The block also enforces x0 = 0 and forwards a same-cycle write to both pipeline read ports.
module regfile_access_ctrl #(
   parameter int unsigned DWIDTH       = 32,
   parameter int unsigned AWIDTH       = 5,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [AWIDTH-1:0] wb_addr,
   input  logic [DWIDTH-1:0] wb_data,
   input  logic [AWIDTH-1:0] pipe_addr_a,
   input  logic [AWIDTH-1:0] pipe_addr_b,
   input  logic              pipe_rb_used,
   output logic [DWIDTH-1:0] pipe_data_a,
   output logic [DWIDTH-1:0] pipe_data_b,
   output logic              pipe_stall,
   output logic              rf_we,
   output logic [AWIDTH-1:0] rf_addr_d,
   output logic [DWIDTH-1:0] rf_data_d,
   output logic [AWIDTH-1:0] rf_addr_a,
   output logic [AWIDTH-1:0] rf_addr_b,
   input  logic [DWIDTH-1:0] rf_data_a,
   input  logic [DWIDTH-1:0] rf_data_b,
   input  logic              dbg_req_valid,
   output logic              dbg_req_ready,
   input  logic              dbg_req_write,
   input  logic [AWIDTH-1:0] dbg_req_addr,
   input  logic [DWIDTH-1:0] dbg_req_wdata,
   output logic              dbg_rsp_valid,
   input  logic              dbg_rsp_ready,
   output logic [DWIDTH-1:0] dbg_rsp_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                stall_q, stall_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                lat_write_q, lat_write_d;
   logic [AWIDTH-1:0]   lat_addr_q, lat_addr_d;
   logic [DWIDTH-1:0]   lat_wdata_q, lat_wdata_d;

   logic                gnt_c;
   logic                dbg_wr_gnt_c;
   logic                dbg_rd_gnt_c;
   logic [AWIDTH-1:0]   wr_addr_c;
   logic [DWIDTH-1:0]   wr_data_c;

   // Return the read value for addr, taking a same-cycle regfile write into account (x0 always reads 0).
   function automatic logic [DWIDTH-1:0] fwd(input logic [AWIDTH-1:0] addr,
                                             input logic [DWIDTH-1:0] rd_data,
                                             input logic              we,
                                             input logic [AWIDTH-1:0] waddr,
                                             input logic [DWIDTH-1:0] wdata);
      if (addr == '0)                 return '0;
      else if (we && (waddr == addr)) return wdata;
      else                            return rd_data;
   endfunction

   // Grant the pending debug access when its port is free or the pipeline is stalled; mux the ports.
   always_comb begin
      gnt_c = 1'b0;
      if (state_q == WAIT)
         gnt_c = lat_write_q ? (!wb_we || stall_q) : (!pipe_rb_used || stall_q);
      dbg_wr_gnt_c = gnt_c && lat_write_q;
      dbg_rd_gnt_c = gnt_c && !lat_write_q;
      wr_addr_c    = dbg_wr_gnt_c ? lat_addr_q  : wb_addr;
      wr_data_c    = dbg_wr_gnt_c ? lat_wdata_q : wb_data;
      rf_we        = (dbg_wr_gnt_c || wb_we) && (wr_addr_c != '0) && !rst;
      rf_addr_d    = wr_addr_c;
      rf_data_d    = wr_data_c;
      rf_addr_a    = pipe_addr_a;
      rf_addr_b    = dbg_rd_gnt_c ? lat_addr_q : pipe_addr_b;
      pipe_data_a  = fwd(pipe_addr_a, rf_data_a, rf_we, wr_addr_c, wr_data_c);
      pipe_data_b  = fwd(pipe_addr_b, rf_data_b, rf_we, wr_addr_c, wr_data_c);
   end

   // Debug handshake sequencing, starvation counting and response capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_d     = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      lat_write_d = lat_write_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      unique case (state_q)
         IDLE: begin
            if (dbg_req_valid && dbg_req_ready) begin
               lat_write_d = dbg_req_write;
               lat_addr_d  = dbg_req_addr;
               lat_wdata_d = dbg_req_wdata;
               cnt_d       = '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (gnt_c) begin
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = lat_write_q ? '0
                           : fwd(lat_addr_q, rf_data_b, rf_we, wr_addr_c, wr_data_c);
               state_d     = RSP;
            end else begin
               cnt_d   = (cnt_q >= LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
               stall_d = (cnt_d >= LIMIT);
            end
         end
         RSP: begin
            if (dbg_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; a reset drops any pending request or response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         lat_write_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_q     <= stall_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         lat_write_q <= lat_write_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
      end
   end

   assign pipe_stall    = stall_q;
   assign dbg_rsp_valid = rsp_valid_q;
   assign dbg_rsp_rdata = rsp_rdata_q;
   assign dbg_req_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: directed scenarios followed by random traffic, all checked
// every cycle against an architectural model of the register file and the debug handshake.
module tb_regfile_access_ctrl;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 5;
   localparam int unsigned LIM = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [AW-1:0] pipe_addr_a, pipe_addr_b;
   logic          pipe_rb_used;
   logic [DW-1:0] pipe_data_a, pipe_data_b;
   logic          pipe_stall;
   logic          rf_we;
   logic [AW-1:0] rf_addr_d, rf_addr_a, rf_addr_b;
   logic [DW-1:0] rf_data_d, rf_data_a, rf_data_b;
   logic          dbg_req_valid, dbg_req_ready, dbg_req_write;
   logic [AW-1:0] dbg_req_addr;
   logic [DW-1:0] dbg_req_wdata;
   logic          dbg_rsp_valid, dbg_rsp_ready;
   logic [DW-1:0] dbg_rsp_rdata;

   regfile_access_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(LIM), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .pipe_addr_a(pipe_addr_a), .pipe_addr_b(pipe_addr_b), .pipe_rb_used(pipe_rb_used),
      .pipe_data_a(pipe_data_a), .pipe_data_b(pipe_data_b), .pipe_stall(pipe_stall),
      .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
      .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
      .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
      .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata)
   );

   always #5 clk = ~clk;

   // Register file RAM: one synchronous write port, two asynchronous read ports.
   logic [DW-1:0] rf_mem [32];
   always_ff @(posedge clk) if (rf_we) rf_mem[rf_addr_d] <= rf_data_d;
   assign rf_data_a = rf_mem[rf_addr_a];
   assign rf_data_b = rf_mem[rf_addr_b];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: architectural register contents plus the debug request life cycle.
   logic [DW-1:0] arch [32];
   int            m_phase = 0;      // 0 = free, 1 = pending, 2 = responding
   bit            m_write;
   int            m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rsp_data = '0;
   int            m_waits = 0;
   bit            m_stall = 0;
   int            stall_cycles = 0;

   function automatic logic [DW-1:0] expect_read(input int a, input bit we, input int wa,
                                                 input logic [DW-1:0] wd);
      if (a == 0)               return '0;
      if (we && wa == a)        return wd;
      return arch[a];
   endfunction

   // One clock cycle: apply inputs, check all outputs against the model, then advance the model.
   task automatic step();
      bit            gnt, wen, exp_we;
      int            wa;
      logic [DW-1:0] wd;
      if (m_stall) begin
         wb_we        = 1'b0;
         pipe_rb_used = 1'b0;
      end
      #1;
      gnt = (m_phase == 1) && (m_write ? (!wb_we || m_stall) : (!pipe_rb_used || m_stall));
      wen = (gnt && m_write) || wb_we;
      wa  = (gnt && m_write) ? m_addr  : int'(wb_addr);
      wd  = (gnt && m_write) ? m_wdata : wb_data;
      exp_we = wen && (wa != 0) && !rst;

      check("pipe_stall", DW'(pipe_stall), DW'(m_stall));
      check("req_ready", DW'(dbg_req_ready), DW'((m_phase == 0) && !rst));
      check("rsp_valid", DW'(dbg_rsp_valid), DW'(m_phase == 2));
      check("rsp_rdata", dbg_rsp_rdata, m_rsp_data);
      check("rf_we", DW'(rf_we), DW'(exp_we));
      if (exp_we) begin
         check("rf_addr_d", DW'(rf_addr_d), DW'(wa));
         check("rf_data_d", rf_data_d, wd);
      end
      check("rf_addr_a", DW'(rf_addr_a), DW'(pipe_addr_a));
      check("rf_addr_b", DW'(rf_addr_b), (gnt && !m_write) ? DW'(m_addr) : DW'(pipe_addr_b));
      check("pipe_data_a", pipe_data_a, expect_read(int'(pipe_addr_a), exp_we, wa, wd));
      if (!(gnt && !m_write))
         check("pipe_data_b", pipe_data_b, expect_read(int'(pipe_addr_b), exp_we, wa, wd));
      if (pipe_stall) stall_cycles++;

      if (rst) begin
         m_phase = 0; m_stall = 0; m_waits = 0; m_rsp_data = '0;
      end else begin
         bit nstall = 0;
         if (exp_we) arch[wa] = wd;
         case (m_phase)
            0: if (dbg_req_valid) begin
                  m_write = dbg_req_write; m_addr = int'(dbg_req_addr);
                  m_wdata = dbg_req_wdata; m_phase = 1; m_waits = 0;
               end
            1: if (gnt) begin
                  m_phase    = 2;
                  m_rsp_data = (m_write || m_addr == 0) ? '0 : arch[m_addr];
                  m_waits    = 0;
               end else begin
                  m_waits = (m_waits + 1 > int'(LIM)) ? int'(LIM) : m_waits + 1;
                  nstall  = (m_waits >= int'(LIM));
               end
            default: if (dbg_rsp_ready) m_phase = 0;
         endcase
         m_stall = nstall;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
      pipe_addr_a = '0; pipe_addr_b = '0; pipe_rb_used = 0;
      dbg_req_valid = 0; dbg_req_write = 0; dbg_req_addr = '0; dbg_req_wdata = '0;
      dbg_rsp_ready = 0;
   endtask

   task automatic dbg_issue(input bit wr, input int a, input logic [DW-1:0] d);
      dbg_req_valid = 1; dbg_req_write = wr; dbg_req_addr = AW'(a); dbg_req_wdata = d;
      step();
      dbg_req_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; arch[i] = '0; end
      quiet();
      rst = 1;
      @(posedge clk); #1;
      step();                              // reset cycle: ready must be low, no write
      rst = 0;
      step();

      // Debug write x5, then read it back.
      dbg_issue(1, 5, 32'hDEADBEEF);
      step();                              // grant cycle (wb idle)
      check("t1_rsp_valid", DW'(dbg_rsp_valid), DW'(1));
      dbg_rsp_ready = 1; step(); dbg_rsp_ready = 0;
      dbg_issue(0, 5, '0);
      step();
      check("t1_rdata", dbg_rsp_rdata, 32'hDEADBEEF);
      dbg_rsp_ready = 1; step(); dbg_rsp_ready = 0;

      // Same-cycle forwarding, then writes to x0 are suppressed.
      wb_we = 1; wb_addr = 7; wb_data = 32'h12345678; pipe_addr_a = 7; step();
      wb_addr = 0; wb_data = 32'hFFFFFFFF; pipe_addr_a = 0; step();
      wb_we = 0; step();

      // Starvation: writeback busy until the stall forces the grant.
      stall_cycles = 0;
      wb_addr = 9; wb_data = 32'h0BADF00D;
      dbg_issue(1, 10, 32'hCAFE0001);
      wb_we = 1;
      for (int k = 0; k < 30 && !dbg_rsp_valid; k++) begin
         wb_we = 1; wb_addr = AW'($urandom_range(1, 31)); step();
      end
      wb_we = 0;
      check("t3_rsp_seen", DW'(dbg_rsp_valid), DW'(1));
      check("t3_stall_cycles", DW'(stall_cycles), DW'(1));
      dbg_rsp_ready = 1; step(); dbg_rsp_ready = 0;

      // Debug read while read port B is busy for two cycles.
      stall_cycles = 0;
      dbg_issue(0, 3, '0);
      pipe_rb_used = 1; pipe_addr_b = 12; step(); step();
      pipe_rb_used = 0; step();
      check("t4_rsp_valid", DW'(dbg_rsp_valid), DW'(1));
      check("t4_no_stall", DW'(stall_cycles), DW'(0));

      // Response back-pressure for five cycles.
      for (int k = 0; k < 5; k++) step();
      dbg_rsp_ready = 1; step(); dbg_rsp_ready = 0;
      check("t5_ready_after", DW'(dbg_req_ready), DW'(1));

      // Reset while a write is pending.
      wb_we = 1; wb_addr = 4; wb_data = 32'h55;
      dbg_issue(1, 6, 32'h66);
      rst = 1; step(); rst = 0; wb_we = 0;
      step();
      check("t6_rsp_valid", DW'(dbg_rsp_valid), DW'(0));

      // Random traffic, with bursts of heavy writeback / read-port use to provoke starvation.
      for (int c = 0; c < 3000; c++) begin
         bit heavy = ((c / 64) % 3) == 1;
         rst           = ($urandom_range(0, 199) == 0);
         wb_we         = heavy ? ($urandom_range(0, 9) != 0) : $urandom_range(0, 1);
         wb_addr       = AW'($urandom_range(0, 7));
         wb_data       = $urandom;
         pipe_addr_a   = AW'($urandom_range(0, 7));
         pipe_addr_b   = AW'($urandom_range(0, 7));
         pipe_rb_used  = heavy ? ($urandom_range(0, 9) != 0) : $urandom_range(0, 1);
         dbg_req_valid = $urandom_range(0, 1);
         dbg_req_write = $urandom_range(0, 1);
         dbg_req_addr  = AW'($urandom_range(0, 7));
         dbg_req_wdata = $urandom;
         dbg_rsp_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
